// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register.
// Handles freeze parking, branch redirect and draining of abandoned requests.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_drain_nxt;
    logic [31:0] w_buf_instr_nxt;
    logic [31:0] w_buf_pc_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_instr_nxt;
    logic        w_if_valid_nxt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;

    assign w_pc_inc = r_pc + 32'd4;
    assign w_target = branch_addr & 32'hFFFF_FFFC;

    assign imem_req    = !rst && (r_state != S_HOLD);
    assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign pc          = r_if_pc;
    assign instruction = r_if_instr;
    assign valid       = r_if_valid;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drain_nxt     = r_drain_addr;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_if_pc_nxt     = r_if_pc;
        w_if_instr_nxt  = r_if_instr;
        w_if_valid_nxt  = r_if_valid;
        if (branch_taken) begin
            w_pc_nxt       = w_target;
            w_if_instr_nxt = 32'h0;
            w_if_valid_nxt = 1'b0;
            unique case (r_state)
                S_FETCH: begin
                    // in-flight request must still complete at its old address
                    if (!imem_ready) begin
                        w_drain_nxt = r_pc;
                        w_state_nxt = S_DRAIN;
                    end
                end
                S_HOLD:  w_state_nxt = S_FETCH;
                S_DRAIN: w_state_nxt = imem_ready ? S_FETCH : S_DRAIN;
                default: w_state_nxt = S_FETCH;
            endcase
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        w_pc_nxt = w_pc_inc;
                        if (freeze) begin
                            w_buf_instr_nxt = imem_rdata;
                            w_buf_pc_nxt    = w_pc_inc;
                            w_state_nxt     = S_HOLD;
                        end else begin
                            w_if_pc_nxt    = w_pc_inc;
                            w_if_instr_nxt = imem_rdata;
                            w_if_valid_nxt = 1'b1;
                        end
                    end else if (!freeze) begin
                        w_if_instr_nxt = 32'h0;
                        w_if_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        w_if_pc_nxt    = r_buf_pc;
                        w_if_instr_nxt = r_buf_instr;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        w_state_nxt = S_FETCH;
                    end
                    if (!freeze) begin
                        w_if_instr_nxt = 32'h0;
                        w_if_valid_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= 32'h0;
            r_buf_instr  <= 32'h0;
            r_buf_pc     <= 32'h0;
            r_if_pc      <= 32'h0;
            r_if_instr   <= 32'h0;
            r_if_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_nxt;
            r_buf_instr  <= w_buf_instr_nxt;
            r_buf_pc     <= w_buf_pc_nxt;
            r_if_pc      <= w_if_pc_nxt;
            r_if_instr   <= w_if_instr_nxt;
            r_if_valid   <= w_if_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, wrap instance, and a randomized
// run checked against an in-order fetch-stream reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;
    logic [31:0] mem_xor;

    logic        imem_req,  req2;
    logic [31:0] imem_addr, addr2;
    logic [31:0] imem_rdata, rdata2;
    logic [31:0] pc, pc2;
    logic [31:0] instruction, instr2;
    logic        valid, valid2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ mem_xor;
    assign rdata2     = addr2 ^ mem_xor;

    if_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .instruction(instruction), .valid(valid)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(imem_ready), .imem_rdata(rdata2),
        .pc(pc2), .instruction(instr2), .valid(valid2)
    );

    typedef struct {
        logic        rst, frz, br;
        logic [31:0] ba;
        logic        rdy, cif, ca, req;
        logic [31:0] addr, pc, ins;
        logic        vld;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic r, logic f, logic b, logic [31:0] ba,
                                logic rdy, logic cif, logic ca, logic req,
                                logic [31:0] a, logic [31:0] p,
                                logic [31:0] ins, logic v);
        vec_t e;
        e.rst = r; e.frz = f; e.br = b; e.ba = ba; e.rdy = rdy;
        e.cif = cif; e.ca = ca; e.req = req; e.addr = a;
        e.pc = p; e.ins = ins; e.vld = v;
        tv.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] exp_next;
    logic        s_v, s_req, s_rdy, s_rst;
    logic [31:0] s_pc, s_ins, s_addr;
    int          ndel;

    initial begin
        mem_xor = 32'h0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        branch_addr = 32'h0; imem_ready = 1'b0;

        //   rst frz br  ba       rdy cif ca req addr      pc        ins       v
        add(1, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0);
        add(1, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   32'h0,   32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h0,   32'h0,   32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h4,   32'h4,   32'h0,   1);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h8,   32'h8,   32'h4,   1);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h8,   32'h8,   32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h8,   32'h8,   32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'hC,   32'hC,   32'h8,   1);
        add(0, 1, 0, 32'h0,   1, 1, 1, 1, 32'h10,  32'h10,  32'hC,   1);
        add(0, 1, 0, 32'h0,   1, 1, 1, 0, 32'h14,  32'h10,  32'hC,   1);
        add(0, 1, 0, 32'h0,   1, 1, 1, 0, 32'h14,  32'h10,  32'hC,   1);
        add(0, 0, 0, 32'h0,   1, 1, 1, 0, 32'h14,  32'h10,  32'hC,   1);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h14,  32'h14,  32'h10,  1);
        add(0, 1, 1, 32'h103, 1, 1, 1, 1, 32'h18,  32'h18,  32'h14,  1);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h100, 32'h18,  32'h0,   0);
        add(0, 0, 1, 32'h20,  1, 1, 1, 1, 32'h104, 32'h104, 32'h100, 1);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h20,  32'h104, 32'h0,   0);
        add(0, 0, 1, 32'h200, 0, 1, 1, 1, 32'h20,  32'h104, 32'h0,   0);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h20,  32'h104, 32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h20,  32'h104, 32'h0,   0);
        add(0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h200, 32'h104, 32'h0,   0);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h204, 32'h204, 32'h200, 1);
        add(1, 0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h204, 32'h0,   0);
        add(0, 0, 0, 32'h0,   0, 1, 1, 1, 32'h0,   32'h0,   32'h0,   0);

        for (int i = 0; i < tv.size(); i++) begin
            rst          = tv[i].rst;
            freeze       = tv[i].frz;
            branch_taken = tv[i].br;
            branch_addr  = tv[i].ba;
            imem_ready   = tv[i].rdy;
            #2;
            chk($sformatf("req[%0d]", i), {31'h0, imem_req}, {31'h0, tv[i].req});
            if (tv[i].ca)
                chk($sformatf("addr[%0d]", i), imem_addr, tv[i].addr);
            if (tv[i].cif) begin
                chk($sformatf("pc[%0d]", i), pc, tv[i].pc);
                chk($sformatf("ins[%0d]", i), instruction, tv[i].ins);
                chk($sformatf("vld[%0d]", i), {31'h0, valid}, {31'h0, tv[i].vld});
            end
            if (i == 1)
                chk("wrap_addr_rst", addr2, 32'hFFFF_FFFC);
            if (i == 3) begin
                chk("wrap_pc", pc2, 32'h0);
                chk("wrap_ins", instr2, 32'hFFFF_FFFC);
                chk("wrap_vld", {31'h0, valid2}, 32'h1);
                chk("wrap_next_addr", addr2, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        mem_xor  = 32'h5A5A_0000;
        exp_next = 32'h0;
        ndel     = 0;
        s_rst    = 1'b1;
        s_req    = 1'b0;
        s_rdy    = 1'b0;
        s_addr   = 32'h0;
        for (int k = 0; k < 3000; k++) begin
            rst          = (k < 2) || ($urandom_range(0, 199) == 0);
            branch_taken = ($urandom_range(0, 15) == 0);
            branch_addr  = $urandom();
            freeze       = ($urandom_range(0, 3) == 0);
            imem_ready   = ($urandom_range(0, 3) != 0);
            #1;
            if (rst) begin
                chk("rnd_req_in_rst", {31'h0, imem_req}, 32'h0);
            end else begin
                chk("rnd_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
                if (!s_rst && s_req && !s_rdy) begin
                    chk("rnd_req_held", {31'h0, imem_req}, 32'h1);
                    chk("rnd_addr_held", imem_addr, s_addr);
                end
            end
            s_rst  = rst;
            s_req  = imem_req;
            s_rdy  = imem_ready;
            s_addr = imem_addr;
            s_v    = valid;
            s_pc   = pc;
            s_ins  = instruction;
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rnd_rst_vld", {31'h0, valid}, 32'h0);
                chk("rnd_rst_pc", pc, 32'h0);
                chk("rnd_rst_ins", instruction, 32'h0);
                exp_next = 32'h0;
            end else if (branch_taken) begin
                chk("rnd_br_vld", {31'h0, valid}, 32'h0);
                chk("rnd_br_ins", instruction, 32'h0);
                chk("rnd_br_pc", pc, s_pc);
                exp_next = branch_addr & 32'hFFFF_FFFC;
            end else if (freeze) begin
                chk("rnd_frz_vld", {31'h0, valid}, {31'h0, s_v});
                chk("rnd_frz_pc", pc, s_pc);
                chk("rnd_frz_ins", instruction, s_ins);
            end else if (valid) begin
                chk("rnd_del_pc", pc, exp_next + 32'd4);
                chk("rnd_del_ins", instruction, exp_next ^ mem_xor);
                exp_next = exp_next + 32'd4;
                ndel++;
            end else begin
                chk("rnd_bub_ins", instruction, 32'h0);
                chk("rnd_bub_pc", pc, s_pc);
            end
        end
        tests++;
        if (ndel < 300) begin
            fails++;
            $display("FAIL rnd_throughput: got %0d deliveries expected at least 300", ndel);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
